// File: rtl/microsequencer_if.sv
// Sequencer <-> control ROM / datapath bundle.
// master: the sequencer; slave: ROM, encoder and condition sources.
interface microsequencer_if;
  logic [63:0] cw;
  logic [7:0]  enc_addr;
  logic [7:0]  cond_bits;
  logic [7:0]  state;
  logic        waiting;
  logic        timeout;

  modport master (
    input  cw,
    input  enc_addr,
    input  cond_bits,
    output state,
    output waiting,
    output timeout
  );

  modport slave (
    output cw,
    output enc_addr,
    output cond_bits,
    input  state,
    input  waiting,
    input  timeout
  );
endinterface

// File: rtl/microsequencer.sv
// Next-address engine for the 256x64 microprogram ROM,
// with single-level return and a WAIT watchdog.
module microsequencer #(
  parameter logic [7:0] RESET_ADDR = 8'd0,
  parameter logic [7:0] ABORT_ADDR = 8'd0,
  parameter logic [7:0] WAIT_LIMIT = 8'd255
) (
  input logic              clk,
  input logic              rst_n,
  microsequencer_if.master bus
);

  typedef enum logic [2:0] {
    N_ENC   = 3'b000,
    N_ZERO  = 3'b001,
    N_INC   = 3'b010,
    N_JMP   = 3'b011,
    N_CBR   = 3'b100,
    N_CBRE  = 3'b101,
    N_WAIT  = 3'b110,
    N_RET   = 3'b111
  } nsel_e;

  nsel_e       w_n;
  logic        w_inv;
  logic        w_mi;
  logic [2:0]  w_s;
  logic [7:0]  w_hi;
  logic [7:0]  w_lo;
  logic        w_mjld;
  logic        w_cond;
  logic        w_wait;
  logic        w_fire;
  logic [7:0]  w_inc;
  logic [7:0]  w_seq;
  logic [7:0]  w_next;
  logic        w_unused;

  logic [7:0]  r_state;
  logic [7:0]  r_ret;
  logic [7:0]  r_wait_cnt;
  logic        r_timeout;

  assign w_n    = nsel_e'(bus.cw[57:55]);
  assign w_inv  = bus.cw[54];
  assign w_mi   = bus.cw[53];
  assign w_s    = bus.cw[52:50];
  assign w_hi   = bus.cw[49:42];
  assign w_lo   = bus.cw[41:34];
  assign w_mjld = bus.cw[33];

  assign w_unused = &{1'b0, bus.cw[63:58], bus.cw[32:0]};

  assign w_cond = bus.cond_bits[w_s] ^ w_inv;
  assign w_inc  = r_state + 8'd1;
  assign w_wait = (w_n == N_WAIT) & ~w_cond;
  assign w_fire = w_wait &
                  (r_wait_cnt == WAIT_LIMIT - 8'd1);

  always_comb begin
    w_seq = w_inc;
    unique case (w_n)
      N_ENC:  w_seq = bus.enc_addr;
      N_ZERO: w_seq = RESET_ADDR;
      N_INC:  w_seq = w_inc;
      N_JMP:  w_seq = w_hi;
      N_CBR:  w_seq = w_cond ? w_hi
                    : (w_mi ? w_lo : w_inc);
      N_CBRE: w_seq = w_cond ? w_hi : bus.enc_addr;
      N_WAIT: w_seq = w_cond ? w_inc : r_state;
      N_RET:  w_seq = r_ret;
      default: w_seq = w_inc;
    endcase
  end

  // A stuck handshake overrides the hold with the abort target
  assign w_next = w_fire ? ABORT_ADDR : w_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RESET_ADDR;
      r_ret      <= 8'd0;
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timeout <= w_fire;
      if (w_mjld)
        r_ret <= w_inc;
      if (w_wait && !w_fire)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      else
        r_wait_cnt <= 8'd0;
    end
  end

  assign bus.state   = r_state;
  assign bus.waiting = w_wait;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_microsequencer.sv
// Randomized + directed bench for microsequencer against
// a behavioural next-address model.
module tb_microsequencer;

  localparam int LIMIT = 4;
  localparam int ABORT = 43;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  int   m_st;
  int   m_ret;
  int   m_cnt;
  int   m_to;

  microsequencer_if bus();

  microsequencer #(
    .RESET_ADDR (8'd0),
    .ABORT_ADDR (8'd43),
    .WAIT_LIMIT (8'd4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(
    input int n, input int inv, input int mi,
    input int s, input int hi, input int lo,
    input int mj);
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[57:55] = n[2:0];
    w[54]    = inv[0];
    w[53]    = mi[0];
    w[52:50] = s[2:0];
    w[49:42] = hi[7:0];
    w[41:34] = lo[7:0];
    w[33]    = mj[0];
    return w;
  endfunction

  function automatic logic [7:0] cb(input int bits);
    logic [7:0] c;
    c = bits[7:0];
    c[7] = 1'b1;
    return c;
  endfunction

  task automatic m_reset();
    m_st  = 0;
    m_ret = 0;
    m_cnt = 0;
    m_to  = 0;
  endtask

  // One microinstruction: drive, check the combinational
  // wait flag, clock, then check the registered outputs.
  task automatic cyc(input logic [63:0] w,
                     input logic [7:0] e,
                     input logic [7:0] c);
    int n, s, hi, lo, inc, nxt, held, cnd;
    bus.cw = w;
    bus.enc_addr = e;
    bus.cond_bits = c;
    n   = int'(w[57:55]);
    s   = int'(w[52:50]);
    hi  = int'(w[49:42]);
    lo  = int'(w[41:34]);
    cnd = int'(c[s]) ^ int'(w[54]);
    inc = (m_st + 1) % 256;
    held = (n == 6 && cnd == 0) ? 1 : 0;
    #1;
    chk("waiting", {31'd0, bus.waiting}, held);
    case (n)
      0: nxt = int'(e);
      1: nxt = 0;
      2: nxt = inc;
      3: nxt = hi;
      4: nxt = cnd != 0 ? hi
             : (w[53] ? lo : inc);
      5: nxt = cnd != 0 ? hi : int'(e);
      6: nxt = cnd != 0 ? inc : m_st;
      default: nxt = m_ret;
    endcase
    m_to = 0;
    if (held == 1 && m_cnt == LIMIT - 1) begin
      nxt = ABORT;
      m_to = 1;
      m_cnt = 0;
    end else begin
      m_cnt = held == 1 ? m_cnt + 1 : 0;
    end
    if (w[33]) m_ret = inc;
    m_st = nxt;
    @(posedge clk);
    #1;
    chk("state", {24'd0, bus.state}, m_st);
    chk("timeout", {31'd0, bus.timeout}, m_to);
  endtask

  task automatic jmp(input int a);
    cyc(mk(3, 0, 0, 0, a, 0, 0), 8'd0, cb(0));
  endtask

  logic [63:0] wx;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.cw = mk(2, 0, 0, 0, 0, 0, 0);
    bus.enc_addr = 8'd0;
    bus.cond_bits = cb(0);
    m_reset();
    #12;
    chk("rst_state", {24'd0, bus.state}, 0);
    chk("rst_timeout", {31'd0, bus.timeout}, 0);
    chk("rst_waiting", {31'd0, bus.waiting}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Dispatch and wrap-around increment
    cyc(mk(0, 0, 0, 0, 0, 0, 0), 8'd25, cb(0));
    chk("enc25", {24'd0, bus.state}, 25);
    jmp(255);
    cyc(mk(2, 0, 0, 0, 0, 0, 0), 8'd0, cb(0));
    chk("inc_wrap", {24'd0, bus.state}, 0);

    // Two-way branch on Z
    cyc(mk(4, 0, 1, 3, 40, 44, 0), 8'd0, cb(8));
    chk("cbr_z1", {24'd0, bus.state}, 40);
    cyc(mk(4, 0, 1, 3, 40, 44, 0), 8'd0, cb(0));
    chk("cbr_z0", {24'd0, bus.state}, 44);
    jmp(30);
    cyc(mk(4, 0, 0, 3, 40, 44, 0), 8'd0, cb(0));
    chk("cbr_inc", {24'd0, bus.state}, 31);
    cyc(mk(4, 1, 1, 3, 40, 44, 0), 8'd0, cb(8));
    chk("cbr_inv1", {24'd0, bus.state}, 44);
    cyc(mk(4, 1, 1, 3, 40, 44, 0), 8'd0, cb(0));
    chk("cbr_inv0", {24'd0, bus.state}, 40);

    // Memory wait resolved before the limit
    jmp(18);
    for (int i = 0; i < 3; i++) begin
      cyc(mk(6, 0, 0, 1, 0, 0, 0), 8'd0, cb(0));
      chk("wait_hold", {24'd0, bus.state}, 18);
    end
    cyc(mk(6, 0, 0, 1, 0, 0, 0), 8'd0, cb(2));
    chk("wait_done", {24'd0, bus.state}, 19);
    chk("wait_cnt0", {24'd0, dut.r_wait_cnt}, 0);

    // Watchdog fires on the 4th held edge
    jmp(20);
    for (int i = 0; i < 4; i++)
      cyc(mk(6, 0, 0, 1, 0, 0, 0), 8'd0, cb(0));
    chk("wd_state", {24'd0, bus.state}, ABORT);
    chk("wd_pulse", {31'd0, bus.timeout}, 1);
    cyc(mk(2, 0, 0, 0, 0, 0, 0), 8'd0, cb(0));
    chk("wd_pulse_end", {31'd0, bus.timeout}, 0);

    // Condition arriving on the limit edge wins
    jmp(20);
    for (int i = 0; i < 3; i++)
      cyc(mk(6, 0, 0, 1, 0, 0, 0), 8'd0, cb(0));
    cyc(mk(6, 0, 0, 1, 0, 0, 0), 8'd0, cb(2));
    chk("wd_race", {24'd0, bus.state}, 21);
    chk("wd_race_to", {31'd0, bus.timeout}, 0);

    // Call / return
    jmp(10);
    cyc(mk(3, 0, 0, 0, 30, 0, 1), 8'd0, cb(0));
    chk("call", {24'd0, bus.state}, 30);
    chk("call_ret", {24'd0, dut.r_ret}, 11);
    cyc(mk(2, 0, 0, 0, 0, 0, 0), 8'd0, cb(0));
    cyc(mk(7, 0, 0, 0, 0, 0, 0), 8'd0, cb(0));
    chk("ret", {24'd0, bus.state}, 11);
    jmp(50);
    cyc(mk(7, 0, 0, 0, 0, 0, 1), 8'd0, cb(0));
    chk("ret_ld", {24'd0, bus.state}, 11);
    chk("ret_ld_reg", {24'd0, dut.r_ret}, 51);
    cyc(mk(7, 0, 0, 0, 0, 0, 0), 8'd0, cb(0));
    chk("ret2", {24'd0, bus.state}, 51);

    // Unknowns in unselected fields must not leak
    wx = mk(3, 0, 0, 0, 77, 0, 0);
    wx[41:34] = 'x;
    wx[52:50] = 'x;
    cyc(wx, 8'd0, cb(0));
    chk("x_jmp", {24'd0, bus.state}, 77);

    // Asynchronous reset in the middle of a wait
    jmp(37);
    cyc(mk(6, 0, 0, 1, 0, 0, 0), 8'd0, cb(0));
    cyc(mk(6, 0, 0, 1, 0, 0, 0), 8'd0, cb(0));
    chk("pre_rst_cnt", {24'd0, dut.r_wait_cnt}, 2);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_state", {24'd0, bus.state}, 0);
    chk("arst_cnt", {24'd0, dut.r_wait_cnt}, 0);
    chk("arst_to", {31'd0, bus.timeout}, 0);
    bus.cw = mk(2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random microprogram walk
    for (int i = 0; i < 600; i++) begin
      int n;
      n = int'($urandom_range(0, 7));
      cyc(mk(n,
             int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)),
             ($urandom_range(0, 3) == 0) ? 1 : 0),
          8'($urandom),
          cb(int'($urandom_range(0, 255))));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
